// File: rtl/psram_responder.sv
// CellularRAM-style burst responder: decodes the PSRAM strobes, serves fixed-latency
// 4-word bursts from an on-chip 16-bit RAM and holds the bus configuration register.
module psram_responder #(
    parameter int          ADDR_BITS = 10,
    parameter int          RLAT      = 8,
    parameter int          WLAT      = 7,
    parameter logic [22:0] BCR_RST   = 23'h009D1F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_clk_en,
    input  logic [22:0] mem_addr,
    input  logic [15:0] mem_data_i,
    output logic [15:0] mem_data_o,
    output logic        mem_data_oe,
    input  logic [1:0]  mem_be,
    input  logic        mem_wen,
    input  logic        mem_oen,
    input  logic        mem_cen,
    input  logic        mem_adv,
    input  logic        mem_cre,
    output logic        mem_wait,
    output logic [22:0] bcr,
    output logic        busy,
    output logic        err,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RLAT  = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WLAT  = 3'd3;
    localparam logic [2:0] S_WDATA = 3'd4;

    localparam int         DEPTH = 1 << ADDR_BITS;
    // Latency counters load with LAT-2: the address edge and the final wait edge
    // are not counted down, giving exactly LAT-1 cycles with mem_wait high.
    localparam logic [3:0] RCNT  = 4'(RLAT - 2);
    localparam logic [3:0] WCNT  = 4'(WLAT - 2);

    logic [2:0]           state;
    logic [3:0]           cnt;
    logic [1:0]           w;
    logic [ADDR_BITS-1:0] ba;
    logic [15:0]          data_q;
    logic                 err_q;
    logic [22:0]          bcr_q;

    logic                 wr_en;
    logic [1:0]           wr_be;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [15:0]          wr_data;

    logic [15:0]          ram [DEPTH];
    logic [ADDR_BITS-1:0] rd_addr;
    logic [15:0]          rd_word;

    logic addr_cyc;
    logic burst_start;
    logic bad_addr;
    logic unused_oen;

    // Output enable is owned by the controller; the responder drives a fixed schedule.
    assign unused_oen  = mem_oen;

    assign addr_cyc    = !mem_cen && !mem_adv;
    assign burst_start = addr_cyc && !mem_cre && mem_clk_en;
    assign bad_addr    = addr_cyc && !mem_cre && !mem_clk_en;

    // Read address runs one word ahead of the bus so mem_data_o can be registered.
    always_comb begin
        rd_addr = ba;
        if (state == S_RDATA) begin
            rd_addr = ba + ADDR_BITS'(w) + ADDR_BITS'(1);
        end
    end
    assign rd_word = ram[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            w       <= 2'd0;
            ba      <= '0;
            data_q  <= 16'd0;
            err_q   <= 1'b0;
            bcr_q   <= BCR_RST;
            wr_en   <= 1'b0;
            wr_be   <= 2'b00;
            wr_addr <= '0;
            wr_data <= 16'd0;
        end else begin
            wr_en <= 1'b0;
            if (addr_cyc && mem_cre) begin
                bcr_q <= mem_addr;
            end
            if (bad_addr) begin
                err_q <= 1'b1;
            end
            if (burst_start) begin
                if (state != S_IDLE) begin
                    err_q <= 1'b1;
                end
                ba     <= mem_addr[ADDR_BITS-1:0];
                w      <= 2'd0;
                data_q <= 16'd0;
                state  <= mem_wen ? S_RLAT : S_WLAT;
                cnt    <= mem_wen ? RCNT : WCNT;
            end else begin
                case (state)
                    S_RLAT, S_WLAT: begin
                        if (mem_cen) begin
                            state <= S_IDLE;
                            err_q <= 1'b1;
                        end else if (cnt == 4'd0) begin
                            w <= 2'd0;
                            if (state == S_RLAT) begin
                                state  <= S_RDATA;
                                data_q <= rd_word;
                            end else begin
                                state <= S_WDATA;
                            end
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RDATA: begin
                        if (w == 2'd3) begin
                            state  <= S_IDLE;
                            data_q <= 16'd0;
                        end else begin
                            data_q <= rd_word;
                            w      <= w + 2'd1;
                        end
                    end
                    S_WDATA: begin
                        if (mem_cen) begin
                            err_q <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= ba + ADDR_BITS'(w);
                            wr_data <= mem_data_i;
                            wr_be   <= ~mem_be;
                        end
                        if (w == 2'd3) begin
                            state <= S_IDLE;
                        end else begin
                            w <= w + 2'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // RAM contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_be[0]) ram[wr_addr][7:0]  <= wr_data[7:0];
            if (wr_be[1]) ram[wr_addr][15:8] <= wr_data[15:8];
        end
    end

    assign mem_data_o  = data_q;
    assign mem_data_oe = (state == S_RDATA);
    assign mem_wait    = (state == S_RLAT) || (state == S_WLAT);
    assign busy        = (state != S_IDLE);
    assign err         = err_q;
    assign bcr         = bcr_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: BCR writes, wrapping bursts, byte masks,
// aborts, pre-empted bursts and a write/read loopback at random addresses.
module tb_psram_responder;

    localparam int RLAT = 8;
    localparam int WLAT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clk_en = 1'b0;
    logic [22:0] mem_addr = 23'd0;
    logic [15:0] mem_data_i = 16'd0;
    logic [15:0] mem_data_o;
    logic        mem_data_oe;
    logic [1:0]  mem_be = 2'b11;
    logic        mem_wen = 1'b1;
    logic        mem_oen = 1'b1;
    logic        mem_cen = 1'b1;
    logic        mem_adv = 1'b1;
    logic        mem_cre = 1'b0;
    logic        mem_wait;
    logic [22:0] bcr;
    logic        busy;
    logic        err;
    logic [2:0]  state_dbg;

    int compared   = 0;
    int mismatched = 0;

    psram_responder #(
        .ADDR_BITS(10), .RLAT(RLAT), .WLAT(WLAT), .BCR_RST(23'h009D1F)
    ) dut (
        .clk(clk), .rst(rst), .mem_clk_en(mem_clk_en), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o), .mem_data_oe(mem_data_oe),
        .mem_be(mem_be), .mem_wen(mem_wen), .mem_oen(mem_oen), .mem_cen(mem_cen),
        .mem_adv(mem_adv), .mem_cre(mem_cre), .mem_wait(mem_wait), .bcr(bcr),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // driver tasks: each starts with its address cycle in the current cycle and
    // returns in cycle T0+LAT+4, so the next burst may follow back-to-back
    task automatic do_write(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be4);
        mem_cen = 1'b0; mem_adv = 1'b0; mem_cre = 1'b0; mem_clk_en = 1'b1; mem_wen = 1'b0;
        mem_addr = {13'($urandom_range(0, 8191)), a};
        tick();
        mem_adv = 1'b1; mem_wen = 1'b1;
        check("wr_wait", 32'(mem_wait), 32'd1);
        for (int i = 0; i < WLAT - 1; i++) tick();
        for (int k = 0; k < 4; k++) begin
            mem_data_i = d[16*k +: 16];
            mem_be     = be4[2*k +: 2];
            tick();
        end
        mem_be = 2'b11;
        check("wr_done_busy", 32'(busy), 32'd0);
        mem_cen = 1'b1;
    endtask

    task automatic do_read(input logic [9:0] a, input logic [63:0] exp, input string tag);
        mem_cen = 1'b0; mem_adv = 1'b0; mem_cre = 1'b0; mem_clk_en = 1'b1; mem_wen = 1'b1;
        mem_addr = {13'($urandom_range(0, 8191)), a};
        tick();
        mem_adv = 1'b1;
        check({tag, "_wait_first"}, {30'd0, mem_wait, busy}, 32'd3);
        for (int i = 0; i < RLAT - 2; i++) tick();
        check({tag, "_wait_last"}, {30'd0, mem_wait, mem_data_oe}, 32'd2);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_word%0d", tag, k), {15'd0, mem_data_oe, mem_data_o},
                  {15'd0, 1'b1, exp[16*k +: 16]});
            tick();
        end
        check({tag, "_end"}, {30'd0, busy, mem_data_oe}, 32'd0);
        mem_cen = 1'b1;
    endtask

    initial begin
        logic [9:0]  ra;
        logic [63:0] rd;
        bit          oe_seen;

        // reset state
        do_reset();
        check("rst_bcr", 32'(bcr), 32'h009D1F);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_oe", 32'(mem_data_oe), 32'd0);
        check("rst_wait", 32'(mem_wait), 32'd0);
        check("rst_data", 32'(mem_data_o), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // BCR write
        mem_cre = 1'b1; mem_cen = 1'b0; mem_adv = 1'b0; mem_addr = 23'h08751F;
        tick();
        mem_cre = 1'b0; mem_cen = 1'b1; mem_adv = 1'b1;
        check("bcr_write", 32'(bcr), 32'h08751F);
        check("bcr_busy", 32'(busy), 32'd0);

        // wrapping write, second write past the wrap, reads across the wrap
        do_write(10'h3FE, 64'h1122_3344_5566_7788, 8'h00);
        do_write(10'h002, 64'h000D_000C_000B_000A, 8'h00);
        do_read(10'h3FE, 64'h1122_3344_5566_7788, "wrap_rd");
        do_read(10'h3FF, 64'h000A_1122_3344_5566, "wrap_rd2");
        do_read(10'h000, 64'h000B_000A_1122_3344, "wrap_rd3");
        check("wrap_err", 32'(err), 32'd0);

        // byte masking
        do_write(10'h010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        do_write(10'h010, 64'h0000_0000_0000_0000, {2'b00, 2'b11, 2'b01, 2'b10});
        do_read(10'h010, 64'h0000_FFFF_00FF_FF00, "mask_rd");
        check("mask_err", 32'(err), 32'd0);

        // loopback at random addresses
        for (int n = 0; n < 32; n++) begin
            ra = 10'($urandom_range(0, 1023));
            rd = {$urandom, $urandom};
            do_write(ra, rd, 8'h00);
            do_read(ra, rd, $sformatf("loop%0d", n));
        end
        check("loop_err", 32'(err), 32'd0);

        // BCR write during a read's latency keeps the burst; a new address cycle pre-empts it
        do_write(10'h100, 64'hA1A1_B2B2_C3C3_D4D4, 8'h00);
        mem_cen = 1'b0; mem_adv = 1'b0; mem_clk_en = 1'b1; mem_wen = 1'b1; mem_addr = 23'h000200;
        tick();
        mem_cre = 1'b1; mem_addr = 23'h012345;
        tick();
        mem_cre = 1'b0; mem_adv = 1'b1;
        check("bcr_busy_val", 32'(bcr), 32'h012345);
        check("bcr_busy_burst", {30'd0, busy, mem_wait}, 32'd3);
        check("bcr_busy_err", 32'(err), 32'd0);
        tick();
        do_read(10'h100, 64'hA1A1_B2B2_C3C3_D4D4, "preempt_rd");
        check("preempt_err", 32'(err), 32'd1);

        // error is cleared only by reset; address cycle without clock enable flags it
        do_reset();
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_bcr", 32'(bcr), 32'h009D1F);
        mem_cen = 1'b0; mem_adv = 1'b0; mem_clk_en = 1'b0; mem_addr = 23'h000040;
        tick();
        mem_cen = 1'b1; mem_adv = 1'b1;
        check("noclk_err", 32'(err), 32'd1);
        check("noclk_busy", 32'(busy), 32'd0);

        // abort during read latency
        do_reset();
        mem_cen = 1'b0; mem_adv = 1'b0; mem_clk_en = 1'b1; mem_wen = 1'b1; mem_addr = 23'h000100;
        tick();
        mem_adv = 1'b1;
        tick();
        check("abort_pre_err", 32'(err), 32'd0);
        tick();
        mem_cen = 1'b1;
        tick();
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_err", 32'(err), 32'd1);
        oe_seen = 1'b0;
        for (int i = 0; i < RLAT + 6; i++) begin
            oe_seen = oe_seen | mem_data_oe;
            tick();
        end
        check("abort_no_oe", 32'(oe_seen), 32'd0);
        check("abort_err_sticky", 32'(err), 32'd1);
        do_reset();
        check("abort_rst_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
